vz16_decode_stage: RTL

- Parametrised, pipelined superscalar decode stage for the VZ16 front end.
- Accepts a fetch bundle of up to DECODE_WIDTH 16-bit instructions per cycle and decodes each lane into a 10-bit micro-op plus register fields and per-lane PC.
- Results go to one registered output slot under a valid/ready handshake; the slot supports flush.
- Sits between fetch queue and rename/dispatch.

---
 rtl/vz16_decode_if.sv | 28 ++
 rtl/vz16_decode_stage.sv | 105 ++++++++++
 2 files changed

// File: rtl/vz16_decode_if.sv
// vz16_decode_if: fetch-side and dispatch-side bundle signals of the decode stage
interface vz16_decode_if #(parameter int DECODE_WIDTH = 2);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [DECODE_WIDTH-1:0]   in_lane_vld;
    logic [16*DECODE_WIDTH-1:0] in_inst;
    logic [15:0]               in_pc;
    logic                      out_valid;
    logic                      out_ready;
    logic [DECODE_WIDTH-1:0]   out_lane_vld;
    logic [10*DECODE_WIDTH-1:0] out_uop;
    logic [16*DECODE_WIDTH-1:0] out_pc;
    logic [4*DECODE_WIDTH-1:0] out_rn;
    logic [4*DECODE_WIDTH-1:0] out_r1;
    logic [4*DECODE_WIDTH-1:0] out_r2;
    logic [DECODE_WIDTH-1:0]   out_illegal;

    modport master (
        output flush, in_valid, in_lane_vld, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_lane_vld, out_uop, out_pc, out_rn, out_r1, out_r2, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_lane_vld, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_lane_vld, out_uop, out_pc, out_rn, out_r1, out_r2, out_illegal
    );
endinterface

// File: rtl/vz16_decode_stage.sv
// vz16_decode_stage: superscalar VZ16 decoder with a single registered, flushable output slot
module vz16_decode_stage #(
    parameter int DECODE_WIDTH = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    vz16_decode_if.slave     bus,
    output logic [CNT_W-1:0] dec_count
);
    logic [10*DECODE_WIDTH-1:0] d_uop;
    logic [16*DECODE_WIDTH-1:0] d_pc;
    logic [4*DECODE_WIDTH-1:0]  d_rn;
    logic [4*DECODE_WIDTH-1:0]  d_r1;
    logic [4*DECODE_WIDTH-1:0]  d_r2;
    logic [DECODE_WIDTH-1:0]    d_vld;
    logic [DECODE_WIDTH-1:0]    d_ill;
    logic [CNT_W-1:0]           pop;
    logic                       accept;
    logic                       drain;

    function automatic logic [9:0] decode_op(input logic [3:0] op);
        logic [9:0] u;
        u = '0;
        casez (op)
            4'b0000: u = 10'h001;
            4'b0001: u = 10'h002;
            4'b001?: u = {1'b0, op[0], 8'h04};
            4'b010?: u = {1'b0, op[0], 8'h08};
            4'b011?: u = {1'b0, op[0], 8'h10};
            4'b100?: u = {1'b0, op[0], 8'h20};
            4'b1010: u = 10'h040;
            4'b1011: u = 10'h000;
            default: u = {op[1:0], 8'h80};
        endcase
        return u;
    endfunction

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush && |bus.in_lane_vld;
    assign drain        = bus.out_valid && bus.out_ready && !bus.flush;

    // Decode every lane; lanes younger than the first valid illegal lane are squashed
    always_comb begin
        logic seen;
        seen  = 1'b0;
        d_uop = '0;
        d_pc  = '0;
        d_rn  = '0;
        d_r1  = '0;
        d_r2  = '0;
        d_vld = '0;
        d_ill = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            d_uop[10*i +: 10] = decode_op(bus.in_inst[16*i +: 4]);
            d_pc[16*i +: 16]  = bus.in_pc + 16'(i);
            d_rn[4*i +: 4]    = bus.in_inst[16*i+4 +: 4];
            d_r1[4*i +: 4]    = bus.in_inst[16*i+8 +: 4];
            d_r2[4*i +: 4]    = bus.in_inst[16*i+12 +: 4];
            d_vld[i]          = bus.in_lane_vld[i] && !seen;
            d_ill[i]          = d_vld[i] && (bus.in_inst[16*i +: 4] == 4'b1011);
            if (d_ill[i]) seen = 1'b1;
        end
    end

    // Number of surviving lanes in the held bundle
    always_comb begin
        pop = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) pop = pop + CNT_W'(bus.out_lane_vld[i]);
    end

    // Output slot: flush kills, accept replaces (even while draining), drain empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_lane_vld <= '0;
            bus.out_uop      <= '0;
            bus.out_pc       <= '0;
            bus.out_rn       <= '0;
            bus.out_r1       <= '0;
            bus.out_r2       <= '0;
            bus.out_illegal  <= '0;
        end else if (bus.flush) begin
            bus.out_valid    <= 1'b0;
            bus.out_lane_vld <= '0;
        end else if (accept) begin
            bus.out_valid    <= 1'b1;
            bus.out_lane_vld <= d_vld;
            bus.out_uop      <= d_uop;
            bus.out_pc       <= d_pc;
            bus.out_rn       <= d_rn;
            bus.out_r1       <= d_r1;
            bus.out_r2       <= d_r2;
            bus.out_illegal  <= d_ill;
        end else if (bus.out_ready) begin
            bus.out_valid    <= 1'b0;
        end
    end

    // Count lanes actually handed to dispatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dec_count <= '0;
        else if (drain) dec_count <= dec_count + pop;
    end
endmodule
